link_frame_rx: RTL and testbench

//  Receive-side frame decoder fed directly by the UART link's 16-bit output (data_out / conv8to16valid).

---
 rtl/link_pkg.sv | 19 +
 rtl/link_frame_rx_if.sv | 10 +
 rtl/link_timeout_timer.sv | 28 ++
 rtl/link_frame_rx.sv | 135 +++++++++++++
 tb/tb_link_frame_rx.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the link framer pair (receive decoder and transmit framer).
package link_pkg;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;
    localparam int          CSUM_W            = 16;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } link_state_t;

    // Modular 16-bit sum; carries out of the top bit are dropped on purpose.
    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [15:0]       word);
        return acc + word;
    endfunction

endpackage

// File: rtl/link_frame_rx_if.sv
// Word stream from the UART 8->16 converter into the frame decoder.
interface link_frame_rx_if;

    logic [15:0] din;
    logic        din_valid;

    modport master (output din, output din_valid);
    modport slave  (input  din, input  din_valid);

endinterface

// File: rtl/link_timeout_timer.sv
// Idle-cycle counter: cleared by activity, saturates at LIMIT and flags expiry while saturated.
module link_timeout_timer #(
    parameter int LIMIT = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (timer != LIMIT_W) begin
            timer <= timer + 1'b1;
        end
    end

    assign expired = (timer == LIMIT_W);

endmodule

// File: rtl/link_frame_rx.sv
// Receive frame decoder: sync hunt, payload capture, optional checksum, link liveness.
// Checksum word and CHECK state are built only when LINK_FRAME_RX_CHECKSUM_EN is defined.
module link_frame_rx
    import link_pkg::*;
#(
    parameter int          NUM_WORDS   = 4,
    parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEFAULT,
    parameter int          TIMEOUT_CYC = 2_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    link_frame_rx_if.slave          rx,
    output logic [NUM_WORDS*16-1:0] payload,
    output logic                    frame_ok,
    output logic                    frame_err,
    output logic                    link_up,
    output logic [7:0]              err_cnt
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    link_state_t            state, state_next;
    logic [IDX_W-1:0]       idx;
    logic [NUM_WORDS*16-1:0] shadow, shadow_next;
    logic                   timed_out, abort;
    logic                   start, accept_word, commit;

    link_timeout_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx.din_valid),
        .expired (timed_out)
    );

    // A strobe landing on the expiry cycle takes priority over the abort.
    assign abort = timed_out && !rx.din_valid;

`ifdef LINK_FRAME_RX_CHECKSUM_EN
    logic [CSUM_W-1:0] sum;
    logic              bad;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_HUNT;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start       = 1'b0;
        accept_word = 1'b0;
        commit      = 1'b0;
`ifdef LINK_FRAME_RX_CHECKSUM_EN
        bad         = 1'b0;
`endif
        if (abort) begin
            state_next = ST_HUNT;
        end else if (rx.din_valid) begin
            unique case (state)
                ST_HUNT: begin
                    if (rx.din == SYNC_WORD) begin
                        start      = 1'b1;
                        state_next = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    accept_word = 1'b1;
                    if (idx == LAST_IDX) begin
`ifdef LINK_FRAME_RX_CHECKSUM_EN
                        state_next = ST_CHECK;
`else
                        commit     = 1'b1;
                        state_next = ST_HUNT;
`endif
                    end
                end
`ifdef LINK_FRAME_RX_CHECKSUM_EN
                ST_CHECK: begin
                    if (rx.din == sum) commit = 1'b1;
                    else               bad    = 1'b1;
                    state_next = ST_HUNT;
                end
`endif
                default: state_next = ST_HUNT;
            endcase
        end
    end

    // Without a checksum the last payload word commits in the same cycle it arrives.
    always_comb begin
        shadow_next = shadow;
        if (accept_word) shadow_next[idx*16 +: 16] = rx.din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            shadow   <= '0;
            payload  <= '0;
            frame_ok <= 1'b0;
            link_up  <= 1'b0;
        end else begin
            frame_ok <= commit;
            shadow   <= shadow_next;
            if (start || abort) begin
                idx <= '0;
            end else if (accept_word) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (commit) payload <= shadow_next;
            if (commit)     link_up <= 1'b1;
            else if (abort) link_up <= 1'b0;
        end
    end

`ifdef LINK_FRAME_RX_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            frame_err <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            frame_err <= bad;
            if (start)            sum <= '0;
            else if (accept_word) sum <= csum_add(sum, rx.din);
            if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign frame_err = 1'b0;
    assign err_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_link_frame_rx.sv
// Randomized and directed bench for link_frame_rx against a word-queue reference model.
// Honours LINK_FRAME_RX_CHECKSUM_EN the same way as the design.
module tb_link_frame_rx;

    localparam int          NUM_WORDS = 4;
    localparam logic [15:0] SYNC      = 16'hA55A;
    localparam int          TIMEOUT   = 40;
`ifdef LINK_FRAME_RX_CHECKSUM_EN
    localparam int          FRAME_LEN = NUM_WORDS + 1;
`else
    localparam int          FRAME_LEN = NUM_WORDS;
`endif

    logic                    clk;
    logic                    rst;
    logic [NUM_WORDS*16-1:0] payload;
    logic                    frame_ok;
    logic                    frame_err;
    logic                    link_up;
    logic [7:0]              err_cnt;

    link_frame_rx_if rx_if ();

    link_frame_rx #(
        .NUM_WORDS   (NUM_WORDS),
        .SYNC_WORD   (SYNC),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_if.slave),
        .payload   (payload),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .link_up   (link_up),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words since the last accepted sync, idle cycles since the last strobe.
    bit                      m_in_frame;
    logic [15:0]             m_words[$];
    int                      m_idle;
    logic [NUM_WORDS*16-1:0] m_payload;
    bit                      m_ok, m_err, m_link;
    int                      m_errcnt;

    function automatic void modelReset();
        m_in_frame = 0;
        m_words.delete();
        m_idle    = 0;
        m_payload = '0;
        m_ok      = 0;
        m_err     = 0;
        m_link    = 0;
        m_errcnt  = 0;
    endfunction

    function automatic void modelStep(input bit v, input logic [15:0] w);
        int s;
        bit good;
        m_ok  = 0;
        m_err = 0;
        if (!v && m_idle == TIMEOUT) begin
            m_in_frame = 0;
            m_words.delete();
            m_link = 0;
        end else if (v) begin
            if (!m_in_frame) begin
                if (w == SYNC) begin
                    m_in_frame = 1;
                    m_words.delete();
                end
            end else begin
                m_words.push_back(w);
                if (m_words.size() == FRAME_LEN) begin
                    m_in_frame = 0;
                    good = 1;
`ifdef LINK_FRAME_RX_CHECKSUM_EN
                    s = 0;
                    for (int i = 0; i < NUM_WORDS; i++) s += int'(m_words[i]);
                    good = ((s % 65536) == int'(w));
`else
                    s = 0;
`endif
                    if (good) begin
                        for (int i = 0; i < NUM_WORDS; i++) m_payload[i*16 +: 16] = m_words[i];
                        m_ok   = 1;
                        m_link = 1;
                    end else begin
                        m_err = 1;
                        if (m_errcnt < 255) m_errcnt++;
                    end
                end
            end
        end
        if (v)                     m_idle = 0;
        else if (m_idle < TIMEOUT) m_idle++;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        check("payload",   64'(payload),   64'(m_payload));
        check("frame_ok",  64'(frame_ok),  64'(m_ok));
        check("frame_err", 64'(frame_err), 64'(m_err));
        check("link_up",   64'(link_up),   64'(m_link));
        check("err_cnt",   64'(err_cnt),   64'(m_errcnt));
    endtask

    // One clock: drive at posedge+1, step model on the edge, compare 1 time unit later.
    task automatic applyStimulus(input bit v, input logic [15:0] w);
        rx_if.din_valid = v;
        rx_if.din       = w;
        @(posedge clk);
        modelStep(v, w);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'($urandom));
    endtask

    task automatic sendFrame(input logic [63:0] p, input logic [15:0] csum_xor, input int max_gap);
        logic [15:0] s;
        s = '0;
        applyStimulus(1'b1, SYNC);
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            applyStimulus(1'b1, p[i*16 +: 16]);
            s = s + p[i*16 +: 16];
        end
`ifdef LINK_FRAME_RX_CHECKSUM_EN
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        applyStimulus(1'b1, s ^ csum_xor);
`else
        s = s ^ csum_xor;
`endif
    endtask

    task automatic applyReset();
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] p;
        rst             = 1'b1;
        rx_if.din_valid = 1'b0;
        rx_if.din       = '0;
        modelReset();
        #2;
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Good frame; expected values written out by hand as well as via the model.
        sendFrame(64'h0040_0030_0020_0010, 16'h0000, 0);
        check("t1_ok",      64'(frame_ok), 64'd1);
        check("t1_payload", 64'(payload),  64'h0040_0030_0020_0010);
        check("t1_link",    64'(link_up),  64'd1);
        idle(1);
        check("t1_ok_pulse", 64'(frame_ok), 64'd0);

`ifdef LINK_FRAME_RX_CHECKSUM_EN
        // Checksum off by one (00A1): error pulse, payload untouched.
        sendFrame(64'h0040_0030_0020_0010, 16'h0001, 0);
        check("t2_err",     64'(frame_err), 64'd1);
        check("t2_ok",      64'(frame_ok),  64'd0);
        check("t2_errcnt",  64'(err_cnt),   64'd1);
        check("t2_payload", 64'(payload),   64'h0040_0030_0020_0010);
        idle(2);
`endif

        // Garbage ahead of a frame is dropped.
        applyStimulus(1'b1, 16'h1234);
        applyStimulus(1'b1, 16'hFFFF);
        sendFrame(64'h0004_0003_0002_0001, 16'h0000, 0);
        check("t3_ok",      64'(frame_ok), 64'd1);
        check("t3_payload", 64'(payload),  64'h0004_0003_0002_0001);
        idle(3);

        // Strobe exactly on the expiry cycle keeps the partial frame alive.
        applyStimulus(1'b1, SYNC);
        applyStimulus(1'b1, 16'h0101);
        idle(TIMEOUT);
        applyStimulus(1'b1, 16'h0202);
        applyStimulus(1'b1, 16'h0303);
        applyStimulus(1'b1, 16'h0404);
`ifdef LINK_FRAME_RX_CHECKSUM_EN
        applyStimulus(1'b1, 16'h0A0A);
`endif
        check("edge_ok",      64'(frame_ok), 64'd1);
        check("edge_payload", 64'(payload),  64'h0404_0303_0202_0101);

        // Sync + 2 words, then silence past the timeout.
        applyStimulus(1'b1, SYNC);
        applyStimulus(1'b1, 16'h1111);
        applyStimulus(1'b1, 16'h2222);
        idle(TIMEOUT + 3);
        check("t4_link",    64'(link_up),   64'd0);
        check("t4_err",     64'(frame_err), 64'd0);
        check("t4_payload", 64'(payload),   64'h0404_0303_0202_0101);
        sendFrame(64'h8888_7777_6666_5555, 16'h0000, 0);
        check("t4_ok",   64'(frame_ok), 64'd1);
        check("t4_link2", 64'(link_up), 64'd1);

        // Reset between payload words 1 and 2.
        applyStimulus(1'b1, SYNC);
        applyStimulus(1'b1, 16'hAAAA);
        applyReset();
        check("t5_payload", 64'(payload), 64'd0);
        check("t5_link",    64'(link_up), 64'd0);
        sendFrame(64'hDDDD_CCCC_BBBB_EEEE, 16'h0000, 0);
        check("t5_ok",      64'(frame_ok), 64'd1);
        check("t5_payload2", 64'(payload), 64'hDDDD_CCCC_BBBB_EEEE);

        // Randomized traffic: garbage, gaps, corrupted checksums, occasional long silence.
        for (int f = 0; f < 80; f++) begin
            p = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, 16'($urandom));
            if ($urandom_range(0, 9) == 0) idle(TIMEOUT + $urandom_range(0, 2) - 1);
            sendFrame(p, ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000, 3);
            idle($urandom_range(0, 4));
        end

`ifdef LINK_FRAME_RX_CHECKSUM_EN
        // Error counter saturates at 255.
        for (int f = 0; f < 260; f++) sendFrame(64'h0000_0000_0000_0001, 16'h8000, 0);
        check("sat_errcnt", 64'(err_cnt), 64'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
